// File: rtl/lift_req_queue.sv
// lift_req_queue: FIFO of hall-call codes feeding the lift controller; drops invalid, duplicate and overflow calls.
// Define LIFT_REQ_DEDUP_EN to enable duplicate-call suppression; otherwise identical calls queue repeatedly.
module lift_req_queue #(
    parameter int DEPTH = 6,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [2:0]    req_in,
    input  logic          done,
    output logic [2:0]    req_out,
    output logic          q_empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          drop
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic          pop, acc, dup, code_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign code_ok = (req_in != 3'b000) && (req_in != 3'b101);
    assign pop     = done & ~q_empty;
    assign acc     = push & code_ok & ~dup & (~full | pop);

`ifdef LIFT_REQ_DEDUP_EN
    // occ marks live slots so a match against stale storage is never a duplicate
    logic [DEPTH-1:0] occ, hit;
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++)
            hit[i] = occ[i] && (mem[i] == req_in) && !(pop && (rd == PW'(i)));
    end
    assign dup = |hit;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            if (pop) occ[rd] <= 1'b0;
            if (acc) occ[wr] <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && acc) mem[wr] <= req_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            drop  <= 1'b0;
        end else begin
            if (acc) wr <= nxt(wr);
            if (pop) rd <= nxt(rd);
            count <= count + CW'(acc) - CW'(pop);
            drop  <= push & ~acc;
        end
    end

    assign q_empty = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign req_out = q_empty ? 3'b000 : mem[rd];
endmodule

// File: tb/tb_lift_req_queue.sv
// tb_lift_req_queue: directed test-plan steps plus random traffic checked against a queue-based model.
module tb_lift_req_queue;
    logic       clk = 1'b0, rst_n = 1'b0, push = 1'b0, done = 1'b0;
    logic [2:0] req_in = 3'b000;
    logic [2:0] req_out;
    logic       q_empty, full, drop;
    logic [2:0] count;

`ifdef LIFT_REQ_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    int         n_asrt = 0, n_fail = 0;
    logic [2:0] q[$];
    logic       exp_drop = 1'b0;

    always #5 clk = ~clk;

    lift_req_queue #(.DEPTH(6), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .req_in(req_in), .done(done),
        .req_out(req_out), .q_empty(q_empty), .full(full), .count(count), .drop(drop)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "/count"}, int'(count), q.size());
        chk({tag, "/q_empty"}, int'(q_empty), int'(q.size() == 0));
        chk({tag, "/full"}, int'(full), int'(q.size() == 6));
        chk({tag, "/req_out"}, int'(req_out), (q.size() != 0) ? int'(q[0]) : 0);
        chk({tag, "/drop"}, int'(drop), int'(exp_drop));
    endtask

    // Applies one cycle of inputs, advances the model by the queue rules, then compares everything.
    task automatic step(input logic p, input logic [2:0] c, input logic d, input logic r, input string tag);
        bit pp, dp, ok, a;
        @(negedge clk);
        push = p; req_in = c; done = d; rst_n = r;
        pp = d && (q.size() != 0);
        dp = 1'b0;
        if (DEDUP)
            foreach (q[i]) if (q[i] == c && !(pp && i == 0)) dp = 1'b1;
        ok = (c != 3'd0) && (c != 3'd5);
        a  = p && ok && !dp && (q.size() < 6 || pp);
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            exp_drop = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            if (a) q.push_back(c);
            exp_drop = p && !a;
        end
        push = 1'b0; done = 1'b0; rst_n = 1'b1;
        cmp_all(tag);
    endtask

    initial begin
        step(1'b1, 3'b010, 1'b1, 1'b0, "reset");
        chk("reset_empty", int'(q_empty), 1);

        step(1'b1, 3'b010, 1'b0, 1'b1, "push2U");
        chk("push2U_head", int'(req_out), 2);
        step(1'b0, 3'b000, 1'b0, 1'b1, "hold");
        chk("hold_count", int'(count), 1);
        step(1'b0, 3'b000, 1'b1, 1'b1, "pop1");
        chk("pop1_out", int'(req_out), 0);

        step(1'b1, 3'b001, 1'b0, 1'b1, "p1U");
        chk("p1U_head", int'(req_out), 1);
        step(1'b1, 3'b111, 1'b0, 1'b1, "p3D");
        step(1'b1, 3'b100, 1'b0, 1'b1, "p4D");
        step(1'b0, 3'b000, 1'b1, 1'b1, "drain_a");
        chk("drain_a_out", int'(req_out), 7);
        step(1'b0, 3'b000, 1'b1, 1'b1, "drain_b");
        chk("drain_b_out", int'(req_out), 4);
        step(1'b0, 3'b000, 1'b1, 1'b1, "drain_c");
        chk("drain_c_empty", int'(q_empty), 1);
        step(1'b0, 3'b000, 1'b1, 1'b1, "done_empty");

        step(1'b1, 3'b011, 1'b0, 1'b1, "dup_a");
        step(1'b1, 3'b011, 1'b0, 1'b1, "dup_b");
        chk("dup_count", int'(count), DEDUP ? 1 : 2);
        chk("dup_drop", int'(drop), int'(DEDUP));
        step(1'b0, 3'b000, 1'b1, 1'b1, "dup_drain_a");
        step(1'b0, 3'b000, 1'b1, 1'b1, "dup_drain_b");

        step(1'b1, 3'b001, 1'b0, 1'b1, "fill1");
        step(1'b1, 3'b010, 1'b0, 1'b1, "fill2");
        step(1'b1, 3'b011, 1'b0, 1'b1, "fill3");
        step(1'b1, 3'b110, 1'b0, 1'b1, "fill4");
        step(1'b1, 3'b111, 1'b0, 1'b1, "fill5");
        step(1'b1, 3'b100, 1'b0, 1'b1, "fill6");
        chk("fill_full", int'(full), 1);
        step(1'b1, 3'b001, 1'b0, 1'b1, "over");
        chk("over_drop", int'(drop), 1);
        chk("over_count", int'(count), 6);
        step(1'b1, 3'b001, 1'b1, 1'b1, "swap");
        chk("swap_drop", int'(drop), 0);
        chk("swap_count", int'(count), 6);
        chk("swap_head", int'(req_out), 2);

        step(1'b1, 3'b101, 1'b0, 1'b1, "inv101");
        chk("inv101_drop", int'(drop), 1);
        step(1'b1, 3'b000, 1'b0, 1'b1, "inv000");
        chk("inv000_drop", int'(drop), 1);
        chk("inv_count", int'(count), 6);

        step(1'b0, 3'b000, 1'b1, 1'b1, "to3_a");
        step(1'b0, 3'b000, 1'b1, 1'b1, "to3_b");
        step(1'b0, 3'b000, 1'b1, 1'b1, "to3_c");
        chk("to3_count", int'(count), 3);
        step(1'b1, 3'b010, 1'b1, 1'b0, "midrst");
        chk("midrst_count", int'(count), 0);
        chk("midrst_out", int'(req_out), 0);

        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 79) != 0), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/lift_req_queue.md
# lift_req_queue

Request FIFO that sits directly upstream of the lift controller FSM. It collects hall-call button codes, drops invalid or duplicate calls, and presents the oldest pending call on `req_out` with a `q_empty` flag. Each entry is retired when the FSM signals it is idle (`done`).

## Interface
Parameters:
- `DEPTH`, default 6: number of entries. Six is enough to hold every distinct valid call.
- `CW`, default 3: count width. Must satisfy 2^CW > DEPTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `push`  in  1  one-cycle strobe: a call is presented on `req_in`.
- `req_in`  in  3  call code:
  - Up calls: 001 = 1U, 010 = 2U, 011 = 3U.
  - Down calls: 110 = 2D, 111 = 3D, 100 = 4D.
  - 000 and 101 are invalid.
- `done`  in  1  consumer idle; it consumes `req_out` this cycle.
- `req_out`  out  3  head entry; 000 (NONE) when empty.
- `q_empty`  out  1  high when the queue holds no entries.
- `full`  out  1  high when count equals `DEPTH`.
- `count`  out  CW  number of valid entries.
- `drop`  out  1  one-cycle pulse the cycle after a push was rejected.

## Operation
- Storage is a circular buffer with head pointer `rd`, tail pointer `wr` and `count`. Both pointers wrap from `DEPTH-1` to 0.
- Pop condition: `pop = done & ~q_empty`.
  - The consumer latches `req_out` in any cycle where `done` is high.
  - Consecutive idle cycles therefore retire one entry per cycle.
  - A `done` pulse while the queue is empty is ignored.
- Push acceptance: `acc = push & valid(req_in) & ~dup & (~full | pop)`.
  - `valid(req_in)` is false for 000 and 101.
  - `dup` is true when `req_in` matches any occupied entry, excluding the head if `pop` is high in the same cycle.
- On an accepted push:
  - `mem[wr] <= req_in`, `wr <= wr+1`.
- On a pop:
  - `rd <= rd+1`.
- Count update:
  - `count <= count + acc - pop`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pushing into a full queue is allowed only when a pop happens in the same cycle.
- Rejected push (`push` high and `acc` low): `drop` goes high in the next cycle.
  - Causes: invalid code, duplicate, or full with no pop.
  - Queue state is unchanged.
- Outputs:
  - `req_out = q_empty ? 3'b000 : mem[rd]`.
  - `q_empty = (count == 0)`.
  - `full = (count == DEPTH)`.
  - All outputs decode directly from registers, with no logic path from `push`, `req_in` or `done`.

## Timing
- Reset: synchronous, active-low. On the first rising edge with `rst_n` low:
  - `rd`, `wr`, `count` and `drop` clear to 0.
  - Outputs become `q_empty` = 1, `full` = 0, `req_out` = 000.
  - Storage contents are don't-care.
- Reset asserted mid-operation discards all pending calls at that edge. `push` and `done` are ignored in that cycle.
- Push latency: a call accepted at edge N is visible on `req_out`/`q_empty` after edge N, if the queue was empty.
- Pop latency: a pop at edge N exposes the next entry (or 000 with `q_empty` = 1) after edge N.
- Push into an empty queue in the same cycle as `done`:
  - There is no pop, since `q_empty` was 1.
  - The entry becomes head next cycle.
  - There is no fall-through.
- Order is strictly FIFO. Dedup never reorders existing entries.

## Configuration
- `LIFT_REQ_DEDUP_EN` defined: duplicate suppression is active, as described above.
- Not defined:
  - `dup` is tied to 0, so identical calls are queued repeatedly.
  - `drop` reports only invalid codes and full rejections.
  - All else is unchanged.

## Test plan
- After reset, push 010 once, then hold `done` = 0.
  - Required: `req_out` = 010, `q_empty` = 0, `count` = 1 from the next cycle.
  - Raise `done` for 1 cycle → `q_empty` = 1, `req_out` = 000.
- Push 001, 111, 100 on consecutive cycles, then hold `done` = 1.
  - Required: `req_out` shows 001, 111, 100 on successive cycles, then 000 with `q_empty` = 1.
- Dedup on: push 011 twice with `done` = 0.
  - Required: `count` = 1 and `drop` pulses once.
  - Dedup off: `count` = 2 and no `drop`.
- Fill with all six valid codes, then push 001 with `done` = 0 → `drop` = 1, `count` stays 6.
  - Repeat the push with `done` = 1 while head = 001 → accepted; `count` stays 6 and 001 becomes the tail.
- Push 101 and 000 → `drop` pulses each time, `count` unchanged.
- With 3 entries queued, assert `rst_n` = 0 for one cycle alongside `push` = 1 → `count` = 0, `q_empty` = 1, `req_out` = 000.
